// File: rtl/counter_pkg.sv
// Shared encodings for the parametrised up/down counter family.
package counter_pkg;

  localparam logic [1:0] CNT_WRAP    = 2'b00;
  localparam logic [1:0] CNT_SAT     = 2'b01;
  localparam logic [1:0] CNT_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/counter_next_calc.sv
// Next-count and terminal decision for one enabled step; purely combinational.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  input  logic [1:0]       count_mode,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] next_count_c,
  output logic             wrap_c,
  output logic             finish_c
);

  // Encoding 11 falls through to wrap behaviour.
  always_comb begin
    next_count_c = count;
    wrap_c       = 1'b0;
    finish_c     = 1'b0;
    if (mode) begin
      // count above max_value (after max_value was lowered) is terminal too
      if (count < max_value) begin
        next_count_c = count + WIDTH'(1);
      end else begin
        unique case (count_mode)
          CNT_SAT: next_count_c = max_value;
          CNT_ONESHOT: begin
            next_count_c = max_value;
            finish_c     = 1'b1;
          end
          default: begin
            next_count_c = '0;
            wrap_c       = 1'b1;
          end
        endcase
      end
    end else begin
      if (count != '0) begin
        next_count_c = count - WIDTH'(1);
      end else begin
        unique case (count_mode)
          CNT_SAT: next_count_c = '0;
          CNT_ONESHOT: begin
            next_count_c = '0;
            finish_c     = 1'b1;
          end
          default: begin
            next_count_c = max_value;
            wrap_c       = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/counter_up_down_param.sv
// General-purpose up/down counter with runtime modulus, clear/load and
// wrap / saturate / one-shot terminal behaviour.
module counter_up_down_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [1:0]       count_mode,
  input  logic [WIDTH-1:0] max_value,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal,
  output logic             wrap_pulse,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);

  state_t           state;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;
  logic             step_finish;
  logic [WIDTH-1:0] load_clamped;

  counter_next_calc #(
    .WIDTH(WIDTH)
  ) u_next (
    .count       (count),
    .mode        (mode),
    .count_mode  (count_mode),
    .max_value   (max_value),
    .next_count_c(step_count),
    .wrap_c      (step_wrap),
    .finish_c    (step_finish)
  );

  assign load_clamped = (load_value > max_value) ? max_value : load_value;
  assign at_terminal  = mode ? (count == max_value) : (count == '0);

  // Priority: reset > clear > load > step > hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= RST_COUNT;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      state      <= ST_RUN;
    end else if (clear) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      state      <= ST_RUN;
    end else if (load) begin
      count      <= load_clamped;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      state      <= ST_RUN;
    end else if (enable && (state == ST_RUN)) begin
      count      <= step_count;
      wrap_pulse <= step_wrap;
      if (step_finish) begin
        state <= ST_DONE;
        done  <= 1'b1;
      end
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_up_down_param.sv
// Scoreboard bench for counter_up_down_param: directed steps push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_counter_up_down_param;
  import counter_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned RV = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         mode;
  logic [1:0]   count_mode;
  logic [W-1:0] max_value;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         at_terminal;
  logic         wrap_pulse;
  logic         done;

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic         wrp;
    logic         dn;
    logic         term;
    string        nm;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  counter_up_down_param #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .count_mode (count_mode),
    .max_value  (max_value),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .at_terminal(at_terminal),
    .wrap_pulse (wrap_pulse),
    .done       (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk({e.nm, " cycle"}, cyc, e.cyc);
      chk({e.nm, " count"}, int'(count), int'(e.cnt));
      chk({e.nm, " wrap_pulse"}, int'(wrap_pulse), int'(e.wrp));
      chk({e.nm, " done"}, int'(done), int'(e.dn));
      chk({e.nm, " at_terminal"}, int'(at_terminal), int'(e.term));
    end
  end

  // Drive one cycle of inputs and push the state expected after the next edge.
  task automatic step(input logic en, input logic md, input logic [1:0] cm,
                      input logic [W-1:0] mx, input logic clr, input logic ld,
                      input logic [W-1:0] lv, input logic [W-1:0] ec,
                      input logic ew, input logic ed, input string nm);
    exp_t e;
    @(negedge clock);
    #1;
    enable = en; mode = md; count_mode = cm; max_value = mx;
    clear = clr; load = ld; load_value = lv;
    e.cyc  = cyc + 1;
    e.cnt  = ec;
    e.wrp  = ew;
    e.dn   = ed;
    e.term = md ? (ec == mx) : (ec == '0);
    e.nm   = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=%0d required=0", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ec;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; count_mode = CNT_WRAP;
    max_value = 4'd15; clear = 1'b0; load = 1'b0; load_value = '0;
    #1;
    chk("reset count", int'(count), RV);
    chk("reset wrap_pulse", int'(wrap_pulse), 0);
    chk("reset done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: free run up, wrap at 15
    step(1, 1, CNT_WRAP, 15, 1, 0, 0, 0, 0, 0, "t1 clear");
    for (int i = 0; i < 20; i++) begin
      ec = W'((i + 1) % 16);
      step(1, 1, CNT_WRAP, 15, 0, 0, 0, ec, ec == 0, 0, "t1 run");
    end

    // 2: down with modulus 9
    step(1, 0, CNT_WRAP, 9, 0, 1, 2, 2, 0, 0, "t2 load");
    step(1, 0, CNT_WRAP, 9, 0, 0, 0, 1, 0, 0, "t2 d1");
    step(1, 0, CNT_WRAP, 9, 0, 0, 0, 0, 0, 0, "t2 d0");
    step(1, 0, CNT_WRAP, 9, 0, 0, 0, 9, 1, 0, "t2 wrap");
    step(1, 0, CNT_WRAP, 9, 0, 0, 0, 8, 0, 0, "t2 d8");

    // 3: saturate at 5 then at 0
    step(1, 1, CNT_SAT, 5, 0, 1, 3, 3, 0, 0, "t3 load");
    step(1, 1, CNT_SAT, 5, 0, 0, 0, 4, 0, 0, "t3 u4");
    step(1, 1, CNT_SAT, 5, 0, 0, 0, 5, 0, 0, "t3 u5");
    step(1, 1, CNT_SAT, 5, 0, 0, 0, 5, 0, 0, "t3 sat");
    step(1, 1, CNT_SAT, 5, 0, 0, 0, 5, 0, 0, "t3 sat");
    for (int i = 4; i >= 0; i--)
      step(1, 0, CNT_SAT, 5, 0, 0, 0, W'(i), 0, 0, "t3 down");
    step(1, 0, CNT_SAT, 5, 0, 0, 0, 0, 0, 0, "t3 sat0");

    // 4: one-shot to 7, hold in DONE, load restarts
    step(1, 1, CNT_ONESHOT, 7, 1, 0, 0, 0, 0, 0, "t4 clear");
    for (int i = 1; i <= 7; i++)
      step(1, 1, CNT_ONESHOT, 7, 0, 0, 0, W'(i), 0, 0, "t4 up");
    step(1, 1, CNT_ONESHOT, 7, 0, 0, 0, 7, 0, 1, "t4 done");
    step(1, 1, CNT_ONESHOT, 7, 0, 0, 0, 7, 0, 1, "t4 hold");
    step(1, 1, CNT_WRAP, 7, 0, 0, 0, 7, 0, 1, "t4 mode in done");
    step(1, 1, CNT_ONESHOT, 7, 0, 1, 3, 3, 0, 0, "t4 load");
    step(1, 1, CNT_ONESHOT, 7, 0, 0, 0, 4, 0, 0, "t4 u4");
    step(1, 1, CNT_ONESHOT, 7, 0, 0, 0, 5, 0, 0, "t4 u5");

    // 5: priority and edge cases
    step(1, 1, CNT_WRAP, 9, 1, 1, 5, 0, 0, 0, "t5 clear>load");
    step(1, 1, CNT_WRAP, 9, 0, 1, 12, 9, 0, 0, "t5 load clamp");
    step(1, 1, CNT_WRAP, 4, 0, 0, 0, 0, 1, 0, "t5 max lowered");
    step(0, 1, CNT_WRAP, 4, 0, 0, 0, 0, 0, 0, "t5 enable off");
    step(1, 1, CNT_WRAP, 0, 0, 0, 0, 0, 1, 0, "t5 max0 wrap");
    step(1, 1, CNT_WRAP, 0, 0, 0, 0, 0, 1, 0, "t5 max0 wrap");
    step(1, 1, CNT_ONESHOT, 0, 0, 0, 0, 0, 0, 1, "t5 max0 oneshot");
    step(1, 0, CNT_WRAP, 9, 0, 1, 9, 9, 0, 0, "t5 load9");
    step(1, 0, CNT_WRAP, 4, 0, 0, 0, 8, 0, 0, "t5 down above max");

    // 6: async reset while in DONE at 6
    step(1, 1, CNT_ONESHOT, 6, 0, 1, 5, 5, 0, 0, "t6 load");
    step(1, 1, CNT_ONESHOT, 6, 0, 0, 0, 6, 0, 0, "t6 u6");
    step(0, 1, CNT_ONESHOT, 6, 0, 0, 0, 6, 0, 0, "t6 idle");
    step(1, 1, CNT_ONESHOT, 6, 0, 0, 0, 6, 0, 1, "t6 done");
    step(0, 1, CNT_ONESHOT, 6, 0, 0, 0, 6, 0, 1, "t6 idle");
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t6 async count", int'(count), RV);
    chk("t6 async done", int'(done), 0);
    chk("t6 async wrap_pulse", int'(wrap_pulse), 0);
    #1;
    reset = 1'b0;
    step(1, 1, CNT_ONESHOT, 6, 0, 0, 0, 4, 0, 0, "t6 resume");
    step(1, 1, CNT_ONESHOT, 6, 0, 0, 0, 5, 0, 0, "t6 resume");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
